// File: rtl/rename_checkpoint_if.sv
// Decode/commit/branch-resolution bundle for the rename stage.
// The master side is decode plus the back end; the slave side is the rename unit.
interface rename_checkpoint_if #(
    parameter int AW = 5,
    parameter int PW = 6,
    parameter int TW = 5,
    parameter int CW = 2
);
    logic          rn_valid;
    logic          rn_ready;
    logic          rn_uses_rw;
    logic [AW-1:0] rn_rw_addr;
    logic [AW-1:0] rn_rs_addr;
    logic [AW-1:0] rn_rt_addr;
    logic          rn_is_branch;
    logic [PW-1:0] rn_rs_phys;
    logic [PW-1:0] rn_rt_phys;
    logic [PW-1:0] rn_rw_phys;
    logic [PW-1:0] rn_old_phys;
    logic [TW-1:0] rn_al_tag;
    logic [CW-1:0] rn_ckpt_id;
    logic          cm_valid;
    logic          cm_ready;
    logic [PW-1:0] cm_free_phys;
    logic          cm_free_valid;
    logic          br_valid;
    logic [CW-1:0] br_ckpt_id;
    logic          br_mispredict;

    modport master (
        output rn_valid, rn_uses_rw, rn_rw_addr, rn_rs_addr, rn_rt_addr, rn_is_branch,
               cm_valid, br_valid, br_ckpt_id, br_mispredict,
        input  rn_ready, rn_rs_phys, rn_rt_phys, rn_rw_phys, rn_old_phys, rn_al_tag,
               rn_ckpt_id, cm_ready, cm_free_phys, cm_free_valid
    );

    modport slave (
        input  rn_valid, rn_uses_rw, rn_rw_addr, rn_rs_addr, rn_rt_addr, rn_is_branch,
               cm_valid, br_valid, br_ckpt_id, br_mispredict,
        output rn_ready, rn_rs_phys, rn_rt_phys, rn_rw_phys, rn_old_phys, rn_al_tag,
               rn_ckpt_id, cm_ready, cm_free_phys, cm_free_valid
    );
endinterface

// File: rtl/rename_checkpoint_unit.sv
// Single-issue register rename: map table, circular free list, active list and
// branch checkpoints with single-cycle mispredict recovery.
module rename_checkpoint_unit #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int AL_DEPTH      = 32,
    parameter int NUM_CKPT      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rename_checkpoint_if.slave   bus
);
    localparam int AW       = $clog2(NUM_ARCH_REGS);
    localparam int PW       = $clog2(NUM_PHYS_REGS);
    localparam int TW       = $clog2(AL_DEPTH);
    localparam int CW       = $clog2(NUM_CKPT);
    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FLW      = $clog2(FL_DEPTH);

    typedef struct packed {
        logic          has_dest;
        logic [AW-1:0] rw;
        logic [PW-1:0] old_phys;
    } al_entry_t;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    function automatic logic [FLW:0] fl_inc(input logic [FLW:0] p);
        if (p[FLW-1:0] == FLW'(FL_DEPTH - 1)) begin
            fl_inc = {~p[FLW], {FLW{1'b0}}};
        end else begin
            fl_inc = p + (FLW+1)'(1);
        end
    endfunction

    function automatic logic [FLW:0] fl_cnt(input logic [FLW:0] h, input logic [FLW:0] t);
        if (h[FLW] == t[FLW]) begin
            fl_cnt = {1'b0, t[FLW-1:0]} - {1'b0, h[FLW-1:0]};
        end else begin
            fl_cnt = (FLW+1)'(FL_DEPTH) - {1'b0, h[FLW-1:0]} + {1'b0, t[FLW-1:0]};
        end
    endfunction

    logic [NUM_ARCH_REGS-1:0][PW-1:0]               rmt_q, rmt_d;
    logic [FL_DEPTH-1:0][PW-1:0]                    fl_q, fl_d;
    logic [FLW:0]                                   fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
    al_entry_t [AL_DEPTH-1:0]                       al_q, al_d;
    logic [TW:0]                                    al_head_q, al_head_d, al_tail_q, al_tail_d;
    logic [NUM_CKPT-1:0]                            ck_valid_q, ck_valid_d;
    logic [NUM_CKPT-1:0][NUM_CKPT-1:0]              ck_older_q, ck_older_d;
    logic [NUM_CKPT-1:0][FLW:0]                     ck_fl_head_q, ck_fl_head_d;
    logic [NUM_CKPT-1:0][TW:0]                      ck_al_tail_q, ck_al_tail_d;
    logic [NUM_CKPT-1:0][NUM_ARCH_REGS-1:0][PW-1:0] ck_rmt_q, ck_rmt_d;

    logic          dest_s, rn_ready_s, rn_fire_s, cm_ready_s, cm_fire_s;
    logic          br_hit_s, resolve_s, mispredict_s, ck_free_found_s;
    logic [CW-1:0] ck_free_id_s;
    logic [FLW:0]  fl_count_s;
    logic [TW:0]   al_count_s;
    logic [NUM_CKPT-1:0] kill_s;

    // Lowest-index free checkpoint and the set squashed by a mispredict on br_ckpt_id.
    always_comb begin
        ck_free_found_s = 1'b0;
        ck_free_id_s    = '0;
        kill_s          = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!ck_valid_q[i]) begin
                ck_free_found_s = 1'b1;
                ck_free_id_s    = CW'(i);
            end else begin
                ck_free_found_s = ck_free_found_s;
            end
        end
        for (int j = 0; j < NUM_CKPT; j++) begin
            kill_s[j] = ck_valid_q[j] &&
                        ((CW'(j) == bus.br_ckpt_id) || ck_older_q[j][bus.br_ckpt_id]);
        end
    end

    // Handshake qualification and occupancy.
    always_comb begin
        dest_s        = bus.rn_uses_rw && (bus.rn_rw_addr != AW'(0));
        fl_count_s    = fl_cnt(fl_head_q, fl_tail_q);
        al_count_s    = al_tail_q - al_head_q;
        br_hit_s      = bus.br_valid && ck_valid_q[bus.br_ckpt_id];
        resolve_s     = br_hit_s && !bus.br_mispredict;
        mispredict_s  = br_hit_s && bus.br_mispredict;
        rn_ready_s    = !(bus.br_valid && bus.br_mispredict) &&
                        (al_count_s < (TW+1)'(AL_DEPTH)) &&
                        (!dest_s || (fl_count_s != (FLW+1)'(0))) &&
                        (!bus.rn_is_branch || ck_free_found_s);
        rn_fire_s     = bus.rn_valid && rn_ready_s;
        cm_ready_s    = (al_count_s != (TW+1)'(0));
        cm_fire_s     = bus.cm_valid && cm_ready_s;
    end

    // Next-state: rename, then branch resolution, then commit (commit touches disjoint state).
    always_comb begin
        rmt_d        = rmt_q;
        fl_d         = fl_q;
        fl_head_d    = fl_head_q;
        fl_tail_d    = fl_tail_q;
        al_d         = al_q;
        al_head_d    = al_head_q;
        al_tail_d    = al_tail_q;
        ck_valid_d   = ck_valid_q;
        ck_older_d   = ck_older_q;
        ck_fl_head_d = ck_fl_head_q;
        ck_al_tail_d = ck_al_tail_q;
        ck_rmt_d     = ck_rmt_q;

        if (rn_fire_s) begin
            if (dest_s) begin
                rmt_d[bus.rn_rw_addr] = fl_q[fl_head_q[FLW-1:0]];
                fl_head_d             = fl_inc(fl_head_q);
            end else begin
                fl_head_d = fl_head_q;
            end
            al_d[al_tail_q[TW-1:0]] = '{has_dest: dest_s, rw: bus.rn_rw_addr,
                                        old_phys: rmt_q[bus.rn_rw_addr]};
            al_tail_d = al_tail_q + (TW+1)'(1);
            // Snapshot is taken after the branch's own rename and AL entry.
            if (bus.rn_is_branch) begin
                ck_valid_d[ck_free_id_s]   = 1'b1;
                ck_older_d[ck_free_id_s]   = ck_valid_q;
                ck_rmt_d[ck_free_id_s]     = rmt_d;
                ck_fl_head_d[ck_free_id_s] = fl_head_d;
                ck_al_tail_d[ck_free_id_s] = al_tail_d;
            end else begin
                ck_valid_d = ck_valid_q;
            end
        end else begin
            al_tail_d = al_tail_q;
        end

        if (resolve_s) begin
            ck_valid_d[bus.br_ckpt_id] = 1'b0;
            for (int j = 0; j < NUM_CKPT; j++) begin
                ck_older_d[j][bus.br_ckpt_id] = 1'b0;
            end
        end else if (mispredict_s) begin
            rmt_d      = ck_rmt_q[bus.br_ckpt_id];
            fl_head_d  = ck_fl_head_q[bus.br_ckpt_id];
            al_tail_d  = ck_al_tail_q[bus.br_ckpt_id];
            ck_valid_d = ck_valid_q & ~kill_s;
            for (int j = 0; j < NUM_CKPT; j++) begin
                ck_older_d[j] = ck_older_q[j] & ~kill_s;
            end
        end else begin
            ck_older_d = ck_older_d;
        end

        if (cm_fire_s) begin
            al_head_d = al_head_q + (TW+1)'(1);
            if (al_q[al_head_q[TW-1:0]].has_dest) begin
                fl_d[fl_tail_q[FLW-1:0]] = al_q[al_head_q[TW-1:0]].old_phys;
                fl_tail_d                = fl_inc(fl_tail_q);
            end else begin
                fl_tail_d = fl_tail_q;
            end
        end else begin
            al_head_d = al_head_q;
        end
    end

    // Combinational rename/commit responses from current state.
    always_comb begin
        bus.rn_ready      = rn_ready_s;
        bus.rn_rs_phys    = rmt_q[bus.rn_rs_addr];
        bus.rn_rt_phys    = rmt_q[bus.rn_rt_addr];
        bus.rn_rw_phys    = fl_q[fl_head_q[FLW-1:0]];
        bus.rn_old_phys   = rmt_q[bus.rn_rw_addr];
        bus.rn_al_tag     = al_tail_q[TW-1:0];
        bus.rn_ckpt_id    = ck_free_id_s;
        bus.cm_ready      = cm_ready_s;
        bus.cm_free_phys  = al_q[al_head_q[TW-1:0]].old_phys;
        bus.cm_free_valid = cm_ready_s && al_q[al_head_q[TW-1:0]].has_dest;
    end

    // State registers; reset gives identity map and a full free list of the upper regs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rmt_q[i] <= PW'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PW'(NUM_ARCH_REGS + i);
            end
            fl_head_q    <= '0;
            fl_tail_q    <= {1'b1, {FLW{1'b0}}};
            al_q         <= '0;
            al_head_q    <= '0;
            al_tail_q    <= '0;
            ck_valid_q   <= '0;
            ck_older_q   <= '0;
            ck_fl_head_q <= '0;
            ck_al_tail_q <= '0;
            ck_rmt_q     <= '0;
        end else begin
            rmt_q        <= rmt_d;
            fl_q         <= fl_d;
            fl_head_q    <= fl_head_d;
            fl_tail_q    <= fl_tail_d;
            al_q         <= al_d;
            al_head_q    <= al_head_d;
            al_tail_q    <= al_tail_d;
            ck_valid_q   <= ck_valid_d;
            ck_older_q   <= ck_older_d;
            ck_fl_head_q <= ck_fl_head_d;
            ck_al_tail_q <= ck_al_tail_d;
            ck_rmt_q     <= ck_rmt_d;
        end
    end
endmodule
